// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_NOT  = 4'h2;
   localparam logic [3:0] OP_NEG  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_MUL  = 4'h6;
   localparam logic [3:0] OP_DIV  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_SHRA = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hA;
   localparam logic [3:0] OP_ROR  = 4'hB;
   localparam logic [3:0] OP_ROL  = 4'hC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_ITER,
      ST_FIX,
      ST_DONE
   } state_e;

   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring) engine.
// load captures operands, step runs one iteration, fix applies the divide correction.
module muldiv_iter #(
   parameter int W = 32
) (
   input  logic           clock,
   input  logic           clear_n,
   input  logic           load,
   input  logic           div,
   input  logic           step,
   input  logic           fix,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           fin,
   output logic           dz,
   output logic [2*W-1:0] res
);

   localparam int CW = $clog2(W) + 1;

   // Two guard bits keep MIN*MIN and the doubled partial remainder in range.
   logic [W+1:0]  acc;
   logic [W+1:0]  m;
   logic [W-1:0]  q;
   logic [W-1:0]  a_hold;
   logic          q_1;
   logic          is_div;
   logic          neg_q;
   logic          neg_r;
   logic [CW-1:0] cnt;

   logic [W-1:0]  a_mag;
   logic [W-1:0]  b_mag;
   logic [W+1:0]  booth;
   logic [W+1:0]  nr_shift;
   logic [W+1:0]  nr;
   logic [W-1:0]  rem_pos;
   logic [W-1:0]  quo;
   logic [W-1:0]  rem;

   always_comb begin
      a_mag    = a[W-1] ? -a : a;
      b_mag    = b[W-1] ? -b : b;
      booth    = acc;
      if (q[0] && !q_1) begin
         booth = acc - m;
      end else if (!q[0] && q_1) begin
         booth = acc + m;
      end
      nr_shift = {acc[W:0], q[W-1]};
      nr       = acc[W+1] ? nr_shift + m : nr_shift - m;
      rem_pos  = acc[W+1] ? acc[W-1:0] + m[W-1:0] : acc[W-1:0];
      quo      = neg_q ? -q : q;
      rem      = neg_r ? -rem_pos : rem_pos;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         acc    <= '0;
         m      <= '0;
         q      <= '0;
         a_hold <= '0;
         q_1    <= 1'b0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         cnt    <= '0;
         acc    <= '0;
         q_1    <= 1'b0;
         is_div <= div;
         a_hold <= a;
         dz     <= div && (b == '0);
         neg_q  <= a[W-1] ^ b[W-1];
         neg_r  <= a[W-1];
         if (div) begin
            q <= a_mag;
            m <= {2'b00, b_mag};
         end else begin
            q <= b;
            m <= {{2{a[W-1]}}, a};
         end
      end else if (step && !fin) begin
         cnt <= cnt + CW'(1);
         if (is_div) begin
            acc <= nr;
            q   <= {q[W-2:0], ~nr[W+1]};
         end else begin
            acc <= {booth[W+1], booth[W+1:1]};
            q   <= {booth[0], q[W-1:1]};
            q_1 <= q[0];
         end
      end else if (fix && is_div) begin
         // Restore a negative remainder, then give each part its final sign.
         if (dz) begin
            acc <= {2'b00, a_hold};
            q   <= '1;
         end else begin
            acc <= {2'b00, rem};
            q   <= quo;
         end
      end
   end

   assign fin = (cnt == CW'(W));
   assign res = {acc[W-1:0], q};

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU: start/busy/done handshake, one-cycle logic/add/shift datapath,
// iterative MUL/DIV via muldiv_iter, registered {HI,LO} result.
module seq_alu
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clock,
   input  logic           clear_n,
   input  logic           start,
   input  logic [3:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           div_by_zero,
   output state_e         fsm_state
);

   localparam int SHW = $clog2(W);

   // Handshake: start is accepted on a rising edge only when busy is low
   // (IDLE or DONE); done is high for the single cycle spent in DONE.
   state_e         state;
   state_e         state_nxt;
   logic [3:0]     op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           accept;
   logic           md_fin;
   logic           md_dz;
   logic           md_fix;
   logic [2*W-1:0] md_res;
   logic [W-1:0]   lo;
   logic [W-1:0]   add_b;
   logic           cin;
   logic [SHW-1:0] sh;
   logic [SHW-1:0] sh_inv;

   assign busy      = (state == ST_EXEC) || (state == ST_ITER) || (state == ST_FIX);
   assign done      = (state == ST_DONE);
   assign accept    = start && !busy;
   assign md_fix    = (state == ST_ITER) && md_fin && (op_q == OP_DIV);
   assign fsm_state = state;

   muldiv_iter #(.W(W)) u_muldiv (
      .clock   (clock),
      .clear_n (clear_n),
      .load    (accept && is_iter_op(op)),
      .div     (op == OP_DIV),
      .step    (state == ST_ITER),
      .fix     (md_fix),
      .a       (a),
      .b       (b),
      .fin     (md_fin),
      .dz      (md_dz),
      .res     (md_res)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = is_iter_op(op) ? ST_ITER : ST_EXEC;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_EXEC: state_nxt = ST_DONE;
         ST_ITER: begin
            if (md_fin) begin
               state_nxt = (op_q == OP_DIV) ? ST_FIX : ST_DONE;
            end
         end
         ST_FIX:  state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Rotates pair a shift by sh with one by (-sh mod W), so sh=0 needs no special case.
   always_comb begin
      lo     = '0;
      sh     = b_q[SHW-1:0];
      sh_inv = -sh;
      cin    = (op_q == OP_SUB);
      add_b  = cin ? ~b_q : b_q;
      case (op_q)
         OP_AND:  lo = a_q & b_q;
         OP_OR:   lo = a_q | b_q;
         OP_NOT:  lo = ~a_q;
         OP_NEG:  lo = ~a_q + W'(1);
         OP_ADD,
         OP_SUB:  lo = a_q + add_b + W'(cin);
         OP_SHR:  lo = a_q >> sh;
         OP_SHRA: lo = $signed(a_q) >>> sh;
         OP_SHL:  lo = a_q << sh;
         OP_ROR:  lo = (a_q >> sh) | (a_q << sh_inv);
         OP_ROL:  lo = (a_q << sh) | (a_q >> sh_inv);
         default: lo = '0;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state       <= ST_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q        <= op;
            a_q         <= a;
            b_q         <= b;
            div_by_zero <= 1'b0;
         end
         case (state)
            ST_EXEC: result <= {{W{1'b0}}, lo};
            ST_ITER: begin
               if (md_fin && (op_q == OP_MUL)) begin
                  result <= md_res;
               end
            end
            ST_FIX: begin
               result      <= md_res;
               div_by_zero <= md_dz;
            end
            default: ;
         endcase
      end
   end

endmodule
